// File: rtl/mem_burst_reader.sv
//==============================================================================
// Module   : mem_burst_reader
// Brief    : Burst read controller streaming words from a flattened memory bus
//            over valid/ready; optional parity via MEM_BURST_READER_PARITY_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_burst_reader #(
  parameter int M = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [(2**M)*(2**M)-1:0]       mem_q,
  input  logic                           start,
  input  logic [M-1:0]                   start_addr,
  input  logic [M:0]                     burst_len,
  input  logic                           dout_ready,
  output logic [(2**M)-1:0]              dout,
  output logic                           dout_valid,
  output logic [M-1:0]                   dout_addr,
  output logic                           busy,
  output logic                           done
`ifdef MEM_BURST_READER_PARITY_EN
  ,
  output logic                           dout_par
`endif
);

  localparam int          W        = 2**M;
  localparam logic [M:0]  FULL_LEN = {1'b1, {M{1'b0}}};
  localparam logic [M:0]  REM_ONE  = {{M{1'b0}}, 1'b1};
  localparam logic [M-1:0] ADDR_ONE = {{(M-1){1'b0}}, 1'b1};

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]   state;
  logic [0:0]   state_nxt;
  logic [M:0]   remaining;
  logic [M:0]   eff_len;
  logic [M-1:0] next_addr;
  logic [M-1:0] load_addr;
  logic [W-1:0] load_word;
  logic         handshake;
  logic         load_first;
  logic         load_next;
  logic         finish;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)  state_nxt = S_BURST;
      S_BURST: if (finish) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    handshake  = 1'b0;
    load_first = 1'b0;
    load_next  = 1'b0;
    finish     = 1'b0;
    case (state)
      S_IDLE:  load_first = start;
      S_BURST: begin
        handshake = dout_ready;
        load_next = dout_ready && (remaining != REM_ONE);
        finish    = dout_ready && (remaining == REM_ONE);
      end
      default: ;
    endcase
  end

  // Zero or anything beyond the word count means a full sweep of memory
  always_comb begin
    if ((burst_len == '0) || (burst_len > FULL_LEN)) begin
      eff_len = FULL_LEN;
    end else begin
      eff_len = burst_len;
    end
  end

  assign next_addr = dout_addr + ADDR_ONE;
  assign load_addr = load_first ? start_addr : next_addr;
  assign load_word = mem_q[{load_addr, {M{1'b0}}} +: W];

  assign busy       = (state == S_BURST);
  assign dout_valid = (state == S_BURST);

  // Datapath: words are snapshotted at load so later memory changes never leak in
  always_ff @(posedge clk) begin
    if (rst) begin
      dout      <= '0;
      dout_addr <= '0;
      remaining <= '0;
      done      <= 1'b0;
`ifdef MEM_BURST_READER_PARITY_EN
      dout_par  <= 1'b0;
`endif
    end else begin
      done <= finish;
      if (load_first || load_next) begin
        dout      <= load_word;
        dout_addr <= load_addr;
        remaining <= load_first ? eff_len : (remaining - REM_ONE);
`ifdef MEM_BURST_READER_PARITY_EN
        dout_par  <= ^load_word;
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_burst_reader.sv
//==============================================================================
// Module   : tb_mem_burst_reader
// Brief    : Self-checking bench for mem_burst_reader (queue-based model plus
//            directed literal expectations).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_burst_reader;

  localparam int M = 4;
  localparam int N = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*16-1:0] mem_q;
  logic          start;
  logic [M-1:0]  start_addr;
  logic [M:0]    burst_len;
  logic          dout_ready;
  logic [15:0]   dout;
  logic          dout_valid;
  logic [M-1:0]  dout_addr;
  logic          busy;
  logic          done;
`ifdef MEM_BURST_READER_PARITY_EN
  logic          dout_par;
`endif

  logic [15:0] mem [N];
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < N; k++) mem_q[k*16 +: 16] = mem[k];
  end

  mem_burst_reader #(.M(M)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_q      (mem_q),
    .start      (start),
    .start_addr (start_addr),
    .burst_len  (burst_len),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_addr  (dout_addr),
    .busy       (busy),
    .done       (done)
`ifdef MEM_BURST_READER_PARITY_EN
    ,
    .dout_par   (dout_par)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Model: a burst is the list of addresses it will visit; each word is read
  // from memory at the moment it becomes the presented word.
  int          m_q[$];
  bit          m_valid = 1'b0;
  logic [15:0] m_dout  = '0;
  logic [3:0]  m_addr  = '0;
  bit          m_done  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_valid = 1'b0; m_dout = '0; m_addr = '0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (!m_valid) begin
        if (start) begin
          int n;
          n = (burst_len == 0 || burst_len > N) ? N : int'(burst_len);
          for (int i = 0; i < n; i++) m_q.push_back((int'(start_addr) + i) % N);
          m_addr  = 4'(m_q[0]);
          m_dout  = mem[m_addr];
          m_valid = 1'b1;
        end
      end else if (dout_ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_valid = 1'b0;
          m_done  = 1'b1;
        end else begin
          m_addr = 4'(m_q[0]);
          m_dout = mem[m_addr];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("dout",       dout,       m_dout);
      chk("dout_addr",  dout_addr,  m_addr);
      chk("dout_valid", dout_valid, m_valid);
      chk("busy",       busy,       m_valid);
      chk("done",       done,       m_done);
`ifdef MEM_BURST_READER_PARITY_EN
      chk("dout_par",   dout_par,   ^m_dout);
`endif
    end
  end

  // Accepted-word log for literal stream checks
  logic [15:0] got_w[$];
  logic [3:0]  got_a[$];
  always @(posedge clk) begin
    if (!rst && dout_valid && dout_ready) begin
      got_w.push_back(dout);
      got_a.push_back(dout_addr);
    end
  end

  task automatic clear_log();
    got_w.delete();
    got_a.delete();
  endtask

  task automatic do_start(input int addr, input int len);
    start      = 1'b1;
    start_addr = 4'(addr);
    burst_len  = 5'(len);
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_done(input string name, output int n);
    n = 0;
    while (n < 64) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    if (!done) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic check_stream(input string name, input int base, input int n);
    chk({name, "_count"}, got_w.size(), n);
    for (int i = 0; i < n && i < got_w.size(); i++) begin
      chk({name, "_word"}, got_w[i], 32'hA000 + ((base + i) % N));
      chk({name, "_addr"}, got_a[i], (base + i) % N);
    end
  endtask

  initial begin
    int n;
    for (int k = 0; k < N; k++) mem[k] = 16'hA000 + 16'(k);
    rst = 1'b1; start = 1'b0; start_addr = '0; burst_len = '0; dout_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_valid", dout_valid, 0);
    chk("reset_dout",  dout, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic burst
    clear_log();
    do_start(3, 4);
    chk("basic_latency_valid", dout_valid, 1);
    chk("basic_first_word", dout, 16'hA003);
    chk("basic_first_addr", dout_addr, 3);
    wait_done("basic", n);
    chk("basic_cycles", n, 4);
    chk("basic_busy_at_done", busy, 0);
    check_stream("basic", 3, 4);

    // Wrap-around, started in the done cycle (back-to-back)
    clear_log();
    do_start(14, 4);
    chk("wrap_first_word", dout, 16'hA00E);
    wait_done("wrap", n);
    chk("wrap_cycles", n, 4);
    check_stream("wrap", 14, 4);
    chk("wrap_last_addr", dout_addr, 1);

    // Full dumps: len 0, 20, 16
    clear_log();
    do_start(5, 0);
    wait_done("dump0", n);
    chk("dump0_cycles", n, 16);
    check_stream("dump0", 5, 16);
    clear_log();
    do_start(5, 20);
    wait_done("dump20", n);
    chk("dump20_cycles", n, 16);
    check_stream("dump20", 5, 16);
    clear_log();
    do_start(0, 16);
    wait_done("dump16", n);
    check_stream("dump16", 0, 16);

    // Backpressure with memory overwrite during stall
    clear_log();
    do_start(3, 4);
    @(negedge clk);
    chk("bp_word_before_stall", dout, 16'hA004);
    dout_ready = 1'b0;
    mem[4] = 16'h1234;
    repeat (3) begin
      @(negedge clk);
      chk("bp_stall_word",  dout, 16'hA004);
      chk("bp_stall_valid", dout_valid, 1);
    end
    dout_ready = 1'b1;
    wait_done("bp", n);
    chk("bp_cycles", n + 4, 7);
    check_stream("bp", 3, 4);
    mem[4] = 16'hA004;

    // Start ignored while busy, including the final handshake cycle
    @(negedge clk);
    clear_log();
    do_start(3, 4);
    @(negedge clk);
    start = 1'b1; start_addr = 4'd9; burst_len = 5'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    wait_done("ign", n);
    start = 1'b0;
    check_stream("ign", 3, 4);
    @(negedge clk);
    chk("ign_idle_after_done", busy, 0);

    // Reset mid-burst, with a competing start
    clear_log();
    do_start(0, 8);
    @(negedge clk);
    @(negedge clk);
    chk("rst_words_before", got_w.size(), 2);
    rst = 1'b1; start = 1'b1; start_addr = 4'd7; burst_len = 5'd3;
    @(negedge clk);
    chk("rst_valid", dout_valid, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_dout",  dout, 0);
    chk("rst_done",  done, 0);
    rst = 1'b0; start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_done", done, 0);
    end
    clear_log();
    do_start(0, 1);
    chk("rst_after_word", dout, 16'hA000);
    wait_done("rst_after", n);
    chk("rst_after_cycles", n, 1);
    check_stream("rst_after", 0, 1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
